// File: rtl/axi4l_mem_master_pkg.sv
// Shared bus widths, FSM encoding and error data for the AXI4-Lite memory master.
package axi4l_mem_master_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_RD_A = 3'd2;
  localparam logic [2:0] ST_RD_D = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic is_busy(input logic [2:0] s);
    return (s == ST_WR) || (s == ST_RD_A) || (s == ST_RD_D);
  endfunction

endpackage

// File: rtl/axi4l_mem_master.sv
// Single-outstanding core request port to AXI4-Lite master bridge.
// Optional bus timeout abort: AXI4L_MEM_MASTER_TIMEOUT_EN.
module axi4l_mem_master
  import axi4l_mem_master_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  logic [2:0]          r_state;
  logic [2:0]          w_state_base;
  logic [2:0]          w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_arvalid;

  logic w_idle;
  logic w_wr;
  logic w_rd_a;
  logic w_rd_d;
  logic w_resp;
  logic w_accept;
  logic w_wr_fin;
  logic w_cap;
  logic w_tmo;

  assign w_idle = (r_state == ST_IDLE);
  assign w_wr   = (r_state == ST_WR);
  assign w_rd_a = (r_state == ST_RD_A);
  assign w_rd_d = (r_state == ST_RD_D);
  assign w_resp = (r_state == ST_RESP);

  assign w_accept = req_valid & w_idle;

  // A channel whose valid already dropped has completed its handshake.
  assign w_wr_fin = (~r_awvalid | m_axi_awready)
                  & (~r_wvalid | m_axi_wready);

  assign w_cap = m_axi_rvalid
               & (w_rd_d | (w_rd_a & m_axi_arready));

  always_comb begin
    w_state_base = r_state;
    unique case (1'b1)
      w_idle: begin
        if (req_valid)
          w_state_base = req_we ? ST_WR : ST_RD_A;
      end
      w_wr: begin
        if (w_wr_fin)
          w_state_base = ST_RESP;
      end
      w_rd_a: begin
        if (m_axi_arready)
          w_state_base = m_axi_rvalid ? ST_RESP : ST_RD_D;
      end
      w_rd_d: begin
        if (m_axi_rvalid)
          w_state_base = ST_RESP;
      end
      w_resp: w_state_base = ST_IDLE;
      default: w_state_base = ST_IDLE;
    endcase
  end

`ifdef AXI4L_MEM_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TW-1:0] r_wait;
  logic          r_err;

  // Abort only when no progress is made in the cycle the limit is hit.
  assign w_tmo = is_busy(r_state)
               & (w_state_base == r_state)
               & (r_wait == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_state_nxt != r_state)
        r_wait <= '0;
      else if (is_busy(r_state))
        r_wait <= r_wait + 1'b1;
      if (w_accept)
        r_err <= 1'b0;
      else if (w_tmo)
        r_err <= 1'b1;
    end
  end

  assign resp_err = r_err & w_resp;
`else
  assign w_tmo    = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign w_state_nxt = w_tmo ? ST_RESP : w_state_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr    <= req_addr;
        r_wdata   <= req_wdata;
        r_wstrb   <= req_wstrb;
        r_awvalid <= req_we;
        r_wvalid  <= req_we;
        r_arvalid <= ~req_we;
      end
      if (r_awvalid & m_axi_awready)
        r_awvalid <= 1'b0;
      if (r_wvalid & m_axi_wready)
        r_wvalid <= 1'b0;
      if (r_arvalid & m_axi_arready)
        r_arvalid <= 1'b0;
      if (w_cap)
        r_rdata <= m_axi_rdata;
      if (w_tmo) begin
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rdata   <= DATA_W'(ERR_DATA);
      end
    end
  end

  assign req_ready     = w_idle;
  assign resp_valid    = w_resp;
  assign resp_rdata    = r_rdata;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = w_rd_a | w_rd_d;

endmodule

// File: tb/tb_axi4l_mem_master.sv
// Directed bench for axi4l_mem_master with a one-entry sram slave model.
// Timeout scenario runs only when AXI4L_MEM_MASTER_TIMEOUT_EN is defined.
module tb_axi4l_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic        s_awrdy;
  logic        s_wrdy;
  logic        s_arrdy;
  logic        s_rv_en;
  logic        s_rv = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [31:0] mem_a = '0;
  logic [31:0] mem_d = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi4l_mem_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .m_axi_awaddr(awaddr),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_araddr(araddr),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata(rdata),
    .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  assign awready = s_awrdy;
  assign wready  = s_wrdy;
  assign arready = s_arrdy;
  assign rvalid  = s_rv & s_rv_en;
  assign rdata   = s_rdata;

  // Registered sram slave: R beat follows the AR handshake by one cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      s_rv <= 1'b0;
    end else begin
      if (awvalid & awready) mem_a <= awaddr;
      if (wvalid & wready) mem_d <= wdata;
      if (rvalid & rready) s_rv <= 1'b0;
      if (arvalid & arready) begin
        s_rv    <= 1'b1;
        s_rdata <= (araddr == mem_a) ? mem_d : 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    s_awrdy   = 1'b1;
    s_wrdy    = 1'b1;
    s_arrdy   = 1'b1;
    s_rv_en   = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write, zero-wait slave
    issue(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF);
    chk("w0_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("w1_valids", {30'd0, awvalid, wvalid}, 32'd3);
    chk("w1_awaddr", awaddr, 32'h0000_0010);
    chk("w1_wdata", wdata, 32'h1234_5678);
    chk("w1_wstrb", 32'(wstrb), 32'hF);
    chk("w1_ready", 32'(req_ready), 32'd0);
    chk("w1_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("w2_resp", 32'(resp_valid), 32'd1);
    chk("w2_err", 32'(resp_err), 32'd0);
    chk("w2_valids", {30'd0, awvalid, wvalid}, 32'd0);
    tick();
    chk("w3_resp", 32'(resp_valid), 32'd0);
    chk("w3_ready", 32'(req_ready), 32'd1);

    // Read back the same address
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("r1_arvalid", 32'(arvalid), 32'd1);
    chk("r1_araddr", araddr, 32'h0000_0010);
    chk("r1_rready", 32'(rready), 32'd1);
    chk("r1_awvalid", 32'(awvalid), 32'd0);
    tick();
    chk("r2_arvalid", 32'(arvalid), 32'd0);
    chk("r2_rready", 32'(rready), 32'd1);
    chk("r2_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("r3_resp", 32'(resp_valid), 32'd1);
    chk("r3_rdata", resp_rdata, 32'h1234_5678);
    chk("r3_err", 32'(resp_err), 32'd0);
    tick();
    chk("r4_resp", 32'(resp_valid), 32'd0);

    // Write with wready lagging awready by 3 cycles
    s_wrdy = 1'b0;
    issue(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'h3);
    tick();
    req_valid = 1'b0;
    chk("l1_valids", {30'd0, awvalid, wvalid}, 32'd3);
    tick();
    chk("l2_valids", {30'd0, awvalid, wvalid}, 32'd1);
    chk("l2_wdata", wdata, 32'hA5A5_0F0F);
    chk("l2_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("l3_wvalid", 32'(wvalid), 32'd1);
    chk("l3_wstrb", 32'(wstrb), 32'h3);
    chk("l3_resp", 32'(resp_valid), 32'd0);
    tick();
    s_wrdy = 1'b1;
    chk("l4_wvalid", 32'(wvalid), 32'd1);
    chk("l4_wdata", wdata, 32'hA5A5_0F0F);
    chk("l4_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("l5_resp", 32'(resp_valid), 32'd1);
    chk("l5_wvalid", 32'(wvalid), 32'd0);
    chk("l5_rdata_hold", resp_rdata, 32'h1234_5678);
    tick();
    chk("l6_resp", 32'(resp_valid), 32'd0);

    // Back-to-back: write then read with req_valid held high
    issue(1'b1, 32'h0000_0030, 32'hCAFE_0042, 4'hF);
    tick();
    issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    chk("b1_ready", 32'(req_ready), 32'd0);
    chk("b1_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd6);
    tick();
    chk("b2_resp", 32'(resp_valid), 32'd1);
    chk("b2_ready", 32'(req_ready), 32'd0);
    chk("b2_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    tick();
    chk("b3_ready", 32'(req_ready), 32'd1);
    chk("b3_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("b4_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd1);
    chk("b4_ready", 32'(req_ready), 32'd0);
    tick();
    chk("b5_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("b6_resp", 32'(resp_valid), 32'd1);
    chk("b6_rdata", resp_rdata, 32'hCAFE_0042);
    tick();

    // Reset while waiting in RD_D
    s_rv_en = 1'b0;
    issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("x1_arvalid", 32'(arvalid), 32'd1);
    tick();
    chk("x2_rready", 32'(rready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("x2_rst_rready", 32'(rready), 32'd0);
    chk("x2_rst_arvalid", 32'(arvalid), 32'd0);
    chk("x2_rst_rdata", resp_rdata, 32'd0);
    tick();
    chk("x3_resp", 32'(resp_valid), 32'd0);
    rst_n   = 1'b1;
    s_rv_en = 1'b1;
    tick();
    chk("x4_resp", 32'(resp_valid), 32'd0);
    chk("x4_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("x5_arvalid", 32'(arvalid), 32'd1);
    tick();
    tick();
    chk("x7_resp", 32'(resp_valid), 32'd1);
    chk("x7_rdata", resp_rdata, 32'hCAFE_0042);
    tick();

`ifdef AXI4L_MEM_MASTER_TIMEOUT_EN
    // Slave never accepts the AR: abort after 8 cycles
    s_arrdy = 1'b0;
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("t1_arvalid", 32'(arvalid), 32'd1);
    for (int i = 2; i <= 8; i++) tick();
    chk("t8_arvalid", 32'(arvalid), 32'd1);
    chk("t8_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("t9_arvalid", 32'(arvalid), 32'd0);
    chk("t9_rready", 32'(rready), 32'd0);
    chk("t9_resp", 32'(resp_valid), 32'd1);
    chk("t9_err", 32'(resp_err), 32'd1);
    chk("t9_rdata", resp_rdata, 32'hDEAD_BEEF);
    tick();
    chk("t10_resp", 32'(resp_valid), 32'd0);
    chk("t10_err", 32'(resp_err), 32'd0);
    s_arrdy = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
